// File: rtl/count_bcd_pkg.sv
// Shared types and constants for the BCD countdown formatter.
// COUNT_BCD_BLANK_EN selects leading-zero blanking of the tens character.
package count_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_A,
    SHIFT_B,
    DONE
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         DIGIT_LIMIT = 99;
  localparam int         STEP_COUNT  = 8;

`ifdef COUNT_BCD_BLANK_EN
  localparam logic [15:0] RESET_CHARS = {ASCII_SPACE, ASCII_ZERO};
`else
  localparam logic [15:0] RESET_CHARS = {ASCII_ZERO, ASCII_ZERO};
`endif

  // Turns the tens/ones BCD digits into the LCD character pair; overflow pins "99".
  function automatic logic [15:0] format_pair(input logic [7:0] bcd_low, input logic ovf);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = {4'b0011, bcd_low[7:4]};
    ones = {4'b0011, bcd_low[3:0]};
`ifdef COUNT_BCD_BLANK_EN
    if (bcd_low[7:4] == 4'd0) begin
      tens = ASCII_SPACE;
    end
`endif
    if (ovf) begin
      tens = ASCII_ZERO | 8'd9;
      ones = ASCII_ZERO | 8'd9;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift in one binary bit.
module bcd_dabble_step (
  input  logic [11:0] bcd_in,
  input  logic        bit_in,
  output logic [11:0] bcd_out
);

  logic [11:0] adjusted;

  always_comb begin
    adjusted = bcd_in;
    for (int i = 0; i < 3; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
    bcd_out = {adjusted[10:0], bit_in};
  end

endmodule

// File: rtl/count_bcd_fmt.sv
// Converts two binary countdown values to ASCII digit pairs, one shared dabble step, 17 cycles.
// Build with COUNT_BCD_BLANK_EN to show a blank instead of a leading zero.
module count_bcd_fmt
  import count_bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rs,
  input  logic        start,
  input  logic [7:0]  cnt1,
  input  logic [7:0]  cnt2,
  output logic        busy,
  output logic        done,
  output logic [15:0] chars1,
  output logic [15:0] chars2,
  output logic        ovf1,
  output logic        ovf2
);

  state_t      state;
  logic [7:0]  cap1;
  logic [7:0]  cap2;
  logic [11:0] acc;
  logic [2:0]  step_cnt;
  logic        dabble_bit;
  logic [11:0] dabble_out;
  logic        last_step;
  logic        capture;
  logic        ovf_a;
  logic        ovf_b;

  // Bits are consumed MSB first, so the step count indexes downward from bit 7.
  assign dabble_bit = (state == SHIFT_B) ? cap2[~step_cnt] : cap1[~step_cnt];
  assign last_step  = (step_cnt == 3'(STEP_COUNT - 1));
  assign capture    = start && ((state == IDLE) || (state == DONE));
  assign ovf_a      = (cap1 > 8'(DIGIT_LIMIT));
  assign ovf_b      = (cap2 > 8'(DIGIT_LIMIT));

  bcd_dabble_step u_step (
    .bcd_in  (acc),
    .bit_in  (dabble_bit),
    .bcd_out (dabble_out)
  );

  // Start is honoured in DONE as well so a held request repeats every 17 cycles.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state    <= IDLE;
      cap1     <= '0;
      cap2     <= '0;
      acc      <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      chars1   <= RESET_CHARS;
      chars2   <= RESET_CHARS;
      ovf1     <= 1'b0;
      ovf2     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (capture) begin
            cap1     <= cnt1;
            cap2     <= cnt2;
            acc      <= '0;
            step_cnt <= '0;
            busy     <= 1'b1;
            state    <= SHIFT_A;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT_A: begin
          acc      <= dabble_out;
          step_cnt <= step_cnt + 3'd1;
          if (last_step) begin
            chars1   <= format_pair(dabble_out[7:0], ovf_a);
            ovf1     <= ovf_a;
            acc      <= '0;
            step_cnt <= '0;
            state    <= SHIFT_B;
          end
        end
        SHIFT_B: begin
          acc      <= dabble_out;
          step_cnt <= step_cnt + 3'd1;
          if (last_step) begin
            chars2   <= format_pair(dabble_out[7:0], ovf_b);
            ovf2     <= ovf_b;
            acc      <= '0;
            step_cnt <= '0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/count_bcd_fmt.md
COUNT_BCD_FMT -- requirements
Module: count_bcd_fmt

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single 50 MHz system clock; all flops are clocked on its rising edge.
REQ-002 SHALL have port rs, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request to convert; sampled only in IDLE.
REQ-004 SHALL have port cnt1, input, 8 bits: road-1 countdown value, binary.
REQ-005 SHALL have port cnt2, input, 8 bits: road-2 countdown value, binary.
REQ-006 SHALL have port busy, output, 1 bit: conversion in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse; the outputs were updated on the same edge.
REQ-008 SHALL have port chars1, output, 16 bits: road-1 ASCII pair; [15:8] is tens, [7:0] is ones; feeds the LCD character field.
REQ-009 SHALL have port chars2, output, 16 bits: road-2 ASCII pair, same layout as chars1.
REQ-010 SHALL have port ovf1, output, 1 bit: set when the last cnt1 conversion exceeded 99.
REQ-011 SHALL have port ovf2, output, 1 bit: set when the last cnt2 conversion exceeded 99.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT_A, SHIFT_B and DONE.
REQ-013 SHALL, in IDLE with start=1 at edge N, capture cnt1 and cnt2 into internal registers, clear the BCD accumulator and step counter, and enter SHIFT_A.
- cnt1/cnt2 changes after edge N SHALL NOT affect the result.
REQ-014 SHALL, in SHIFT_A, perform one double-dabble step per cycle on the captured cnt1 (add 3 to each BCD nibble >=5, then shift left 1 bit) for exactly 8 steps (edges N+1..N+8), then enter SHIFT_B.
REQ-015 SHALL, in SHIFT_B, perform the same 8 steps on the captured cnt2 (edges N+9..N+16), then enter DONE.
REQ-016 SHALL, at the transition edges, write the outputs:
- SHIFT_A->SHIFT_B edge: chars1 and ovf1.
- SHIFT_B->DONE edge: chars2 and ovf2.
- The BCD accumulator SHALL be 12 bits (hundreds, tens, ones).
REQ-017 SHALL drive done=1 only in DONE (the cycle after edge N+16) and return to IDLE at edge N+17.
REQ-018 SHALL drive busy=1 in SHIFT_A, SHIFT_B and DONE, and busy=0 in IDLE.
REQ-019 SHALL ignore start while not in IDLE; the request is not queued.
- start held high continuously SHALL restart at edge N+17 (back-to-back, period 17 cycles).
REQ-020 SHALL map digits as ASCII {4'b0011, digit}.
- Value >99: chars = "99" (16'h3939) and ovf=1.
- Otherwise: ovf=0; the hundreds digit is discarded.
REQ-021 SHALL hold chars1, chars2, ovf1 and ovf2 stable between writes.

Reset
REQ-022 SHALL, on rs=0 at any time, asynchronously force:
- state IDLE; busy=0, done=0, ovf1=0, ovf2=0;
- chars1=chars2=16'h3030 ("00"), or 16'h2030 with the blanking option;
- internal registers cleared.
REQ-023 SHALL, if reset interrupts a conversion, leave no partial result; the first post-reset start performs a full conversion.

Configuration
REQ-024 SHALL support macro COUNT_BCD_BLANK_EN (leading-zero blanking).
- Defined: a tens digit of 0 with ovf=0 outputs 8'h20 (space) instead of 8'h30.
- Undefined: the tens digit is always an ASCII digit.
- Timing is identical either way.

Structure
REQ-025 SHALL place the FSM state enum, ASCII_ZERO=8'h30, ASCII_SPACE=8'h20, DIGIT_LIMIT=99 and STEP_COUNT=8 in a shared package, count_bcd_pkg.
REQ-026 SHALL implement the add-3-and-shift step as a combinational sub-module, bcd_dabble_step (12-bit BCD plus 1 input bit in, 12-bit BCD out), instantiated once and shared by SHIFT_A and SHIFT_B.

Verification
REQ-027 Reset, then cnt1=8'd45, cnt2=8'd7, start pulse at edge N:
- done=1 in the cycle after edge N+16;
- chars1=16'h3435, chars2=16'h3037 (16'h2037 with BLANK_EN);
- ovf1=ovf2=0.
REQ-028 cnt1=8'd0, cnt2=8'd99:
- chars1=16'h3030 (16'h2030 with BLANK_EN), chars2=16'h3939, ovf=0.
REQ-029 cnt1=8'd100, cnt2=8'd255:
- chars1=chars2=16'h3939, ovf1=ovf2=1.
- A following conversion of 8'd12 clears ovf1 and yields 16'h3132.
REQ-030 start pulsed at N+5 and at N+16 during a conversion, with cnt inputs changed at N+3:
- both pulses are ignored;
- the result reflects the values captured at N;
- the single done pulse occurs at N+17's cycle.
REQ-031 rs=0 asserted at N+10, mid-SHIFT_B:
- busy and done go 0 immediately;
- outputs return to their reset values;
- a subsequent start yields a correct result 17 cycles later.
